// File: rtl/vga_scaler_pkg.sv
// Shared scale-mode codes and default visible-area timing for the VGA image scaler.
package vga_scaler_pkg;

    typedef enum logic [2:0] {
        MODE_1X    = 3'b000,
        MODE_ZOOM2 = 3'b001,
        MODE_ZOOM4 = 3'b010,
        MODE_DEC2  = 3'b011,
        MODE_DEC4  = 3'b100
    } scale_mode_e;

    localparam int H_ACTIVE_DEF = 640;
    localparam int V_ACTIVE_DEF = 480;

    // Codes above MODE_DEC4 are reserved and must never reach the mode register.
    function automatic logic mode_is_valid(input logic [2:0] i_code);
        return (i_code <= 3'b100);
    endfunction

endpackage

// File: rtl/vga_img_scaler_pipe_delay.sv
// Fixed-depth shift register used to keep per-pixel flags aligned with the memory read.
module pipe_delay #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 2
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_stage [DEPTH];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_stage[i] <= '0;
            end
        end else begin
            r_stage[0] <= i_d;
            for (int i = 1; i < DEPTH; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_q = r_stage[DEPTH-1];

endmodule

// File: rtl/vga_img_scaler.sv
// Maps display coordinates onto a centred, scaled source image and returns the
// fetched pixel (or a border value) a fixed 2+MEM_LAT clocks later.
module vga_img_scaler
    import vga_scaler_pkg::*;
#(
    parameter int IMG_W    = 160,
    parameter int IMG_H    = 120,
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int ADDR_W   = 17,
    parameter int PIX_W    = 8,
    parameter int MEM_LAT  = 2,
    parameter int BORDER   = 0
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [2:0]        i_mode,
    input  logic              i_frame_start,
    input  logic [9:0]        i_next_x,
    input  logic [9:0]        i_next_y,
    output logic [ADDR_W-1:0] o_mem_addr,
    input  logic [PIX_W-1:0]  i_mem_q,
    output logic [PIX_W-1:0]  o_pixel_out,
    output logic              o_in_window,
    output logic [2:0]        o_mode_active
);

    localparam logic [PIX_W-1:0] BORDER_PIX = PIX_W'(BORDER);

    if ((4 * IMG_W > H_ACTIVE) || (4 * IMG_H > V_ACTIVE)) begin : g_bad_size
        $error("vga_img_scaler: 4x zoom of the source image does not fit the visible area");
    end
    if (IMG_W * IMG_H > (1 << ADDR_W)) begin : g_bad_addr
        $error("vga_img_scaler: source image does not fit the address space");
    end
    if ((MEM_LAT < 1) || (MEM_LAT > 4)) begin : g_bad_lat
        $error("vga_img_scaler: MEM_LAT must be 1..4");
    end

    scale_mode_e       r_mode_active;
    logic [31:0]       w_sw, w_sh, w_ox, w_oy;
    logic [1:0]        w_zsh, w_dsh;
    logic [31:0]       w_x, w_y, w_dx, w_dy, w_sx, w_sy;
    logic              w_inside;
    logic [ADDR_W-1:0] w_addr;
    logic [ADDR_W-1:0] r_addr_p1;
    logic              r_vld_p1;
    logic              w_vld_dly;
    logic [PIX_W-1:0]  r_pix_p2;
    logic              r_vld_p2;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_mode_active <= MODE_1X;
        end else if (i_frame_start && mode_is_valid(i_mode)) begin
            r_mode_active <= scale_mode_e'(i_mode);
        end
    end

    // Window geometry is a pure function of the active mode; zoom shifts the
    // offset right, decimate shifts it left.
    always_comb begin
        w_sw  = 32'(IMG_W);
        w_sh  = 32'(IMG_H);
        w_zsh = 2'd0;
        w_dsh = 2'd0;
        case (r_mode_active)
            MODE_ZOOM2: begin w_sw = 32'(2 * IMG_W); w_sh = 32'(2 * IMG_H); w_zsh = 2'd1; end
            MODE_ZOOM4: begin w_sw = 32'(4 * IMG_W); w_sh = 32'(4 * IMG_H); w_zsh = 2'd2; end
            MODE_DEC2:  begin w_sw = 32'(IMG_W / 2); w_sh = 32'(IMG_H / 2); w_dsh = 2'd1; end
            MODE_DEC4:  begin w_sw = 32'(IMG_W / 4); w_sh = 32'(IMG_H / 4); w_dsh = 2'd2; end
            default:    ;
        endcase
        w_ox = (32'(H_ACTIVE) - w_sw) >> 1;
        w_oy = (32'(V_ACTIVE) - w_sh) >> 1;
    end

    assign w_x = 32'(i_next_x);
    assign w_y = 32'(i_next_y);

    assign w_inside = (w_x < 32'(H_ACTIVE)) && (w_y < 32'(V_ACTIVE)) &&
                      (w_x >= w_ox) && (w_x < w_ox + w_sw) &&
                      (w_y >= w_oy) && (w_y < w_oy + w_sh);

    assign w_dx = w_x - w_ox;
    assign w_dy = w_y - w_oy;
    assign w_sx = (w_dx >> w_zsh) << w_dsh;
    assign w_sy = (w_dy >> w_zsh) << w_dsh;

    // IMG_W is an elaboration constant, so this reduces to shift-and-add.
    assign w_addr = w_inside ? ADDR_W'(w_sy * 32'(IMG_W) + w_sx) : '0;

    // ---- stage p1: address issue ----
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_addr_p1 <= '0;
            r_vld_p1  <= 1'b0;
        end else begin
            r_addr_p1 <= w_addr;
            r_vld_p1  <= w_inside;
        end
    end

    pipe_delay #(
        .WIDTH (1),
        .DEPTH (MEM_LAT)
    ) u_flag_dly (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_d     (r_vld_p1),
        .o_q     (w_vld_dly)
    );

    // ---- stage p2: memory data capture ----
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pix_p2 <= BORDER_PIX;
            r_vld_p2 <= 1'b0;
        end else begin
            r_pix_p2 <= w_vld_dly ? i_mem_q : BORDER_PIX;
            r_vld_p2 <= w_vld_dly;
        end
    end

    assign o_mem_addr    = r_addr_p1;
    assign o_pixel_out   = r_pix_p2;
    assign o_in_window   = r_vld_p2;
    assign o_mode_active = r_mode_active;

endmodule

// File: tb/tb_vga_img_scaler.sv
// Scoreboard bench for vga_img_scaler: directed and random coordinates against a
// behavioural window/address model, with a modelled fixed-latency memory.
module tb_vga_img_scaler;

    localparam int IMG_W    = 160;
    localparam int IMG_H    = 120;
    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;
    localparam int ADDR_W   = 17;
    localparam int PIX_W    = 8;
    localparam int MEM_LAT  = 2;
    localparam int BORDER   = 165;

    logic              clk;
    logic              rst_n;
    logic [2:0]        mode;
    logic              frame_start;
    logic [9:0]        next_x, next_y;
    logic [ADDR_W-1:0] mem_addr;
    logic [PIX_W-1:0]  mem_q;
    logic [PIX_W-1:0]  pixel_out;
    logic              in_window;
    logic [2:0]        mode_active;

    vga_img_scaler #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .H_ACTIVE(H_ACTIVE), .V_ACTIVE(V_ACTIVE),
        .ADDR_W(ADDR_W), .PIX_W(PIX_W), .MEM_LAT(MEM_LAT), .BORDER(BORDER)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_mode(mode), .i_frame_start(frame_start),
        .i_next_x(next_x), .i_next_y(next_y), .o_mem_addr(mem_addr), .i_mem_q(mem_q),
        .o_pixel_out(pixel_out), .o_in_window(in_window), .o_mode_active(mode_active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    logic [PIX_W-1:0] mem [0:(1<<ADDR_W)-1];
    logic [PIX_W-1:0] mq [MEM_LAT];
    always @(posedge clk) begin
        mq[0] <= mem[mem_addr];
        for (int i = 1; i < MEM_LAT; i++) mq[i] <= mq[i-1];
    end
    assign mem_q = mq[MEM_LAT-1];

    typedef struct { int due; int addr; int mode; } a_t;
    typedef struct { int due; int inw; int pix; } p_t;
    a_t aq[$];
    p_t pq[$];

    int total = 0;
    int bad = 0;
    int model_mode = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    // Reference: window and source coordinate from plain arithmetic on the mode's scale.
    task automatic ref_model(input int md, input int x, input int y, output bit in, output int addr);
        int sw, sh, ox, oy, sx, sy;
        case (md)
            1: begin sw = 2 * IMG_W; sh = 2 * IMG_H; end
            2: begin sw = 4 * IMG_W; sh = 4 * IMG_H; end
            3: begin sw = IMG_W / 2; sh = IMG_H / 2; end
            4: begin sw = IMG_W / 4; sh = IMG_H / 4; end
            default: begin sw = IMG_W; sh = IMG_H; end
        endcase
        ox = (H_ACTIVE - sw) / 2;
        oy = (V_ACTIVE - sh) / 2;
        in = (x < H_ACTIVE) && (y < V_ACTIVE) && (x >= ox) && (x < ox + sw) &&
             (y >= oy) && (y < oy + sh);
        case (md)
            1: begin sx = (x - ox) / 2; sy = (y - oy) / 2; end
            2: begin sx = (x - ox) / 4; sy = (y - oy) / 4; end
            3: begin sx = (x - ox) * 2; sy = (y - oy) * 2; end
            4: begin sx = (x - ox) * 4; sy = (y - oy) * 4; end
            default: begin sx = x - ox; sy = y - oy; end
        endcase
        addr = in ? ((sy * IMG_W + sx) % (1 << ADDR_W)) : 0;
    endtask

    // Drive one coordinate, queue its expectations, advance to the next negedge.
    task automatic step(input int x, input int y, input bit fs, input int md,
                        input bit dir, input int eaddr, input bit ein);
        int a;
        bit in;
        a_t ae;
        p_t pe;
        next_x = 10'(x);
        next_y = 10'(y);
        frame_start = fs;
        mode = 3'(md);
        if (dir) begin
            a = eaddr;
            in = ein;
        end else begin
            ref_model(model_mode, x, y, in, a);
        end
        if (fs && md <= 4) model_mode = md;
        ae.due = cyc + 1; ae.addr = a; ae.mode = model_mode;
        aq.push_back(ae);
        pe.due = cyc + 2 + MEM_LAT; pe.inw = int'(in);
        pe.pix = in ? int'(mem[a]) : BORDER;
        pq.push_back(pe);
        @(negedge clk);
    endtask

    task automatic release_rst();
        p_t pe;
        rst_n = 1'b1;
        for (int k = 1; k <= 1 + MEM_LAT; k++) begin
            pe.due = cyc + k; pe.inw = 0; pe.pix = BORDER;
            pq.push_back(pe);
        end
    endtask

    task automatic chk_rst(input string tag);
        chk({tag, "_addr"}, int'(mem_addr), 0);
        chk({tag, "_pix"}, int'(pixel_out), BORDER);
        chk({tag, "_inw"}, int'(in_window), 0);
        chk({tag, "_mode"}, int'(mode_active), 0);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            while (aq.size() > 0 && aq[0].due <= cyc) begin
                a_t e;
                e = aq.pop_front();
                chk("addr", int'(mem_addr), e.addr);
                chk("mode", int'(mode_active), e.mode);
            end
            while (pq.size() > 0 && pq[0].due <= cyc) begin
                p_t e;
                e = pq.pop_front();
                chk("inw", int'(in_window), e.inw);
                chk("pix", int'(pixel_out), e.pix);
            end
        end
    end

    initial begin
        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = PIX_W'($urandom);
        rst_n = 1'b0;
        mode = 3'd0;
        frame_start = 1'b0;
        next_x = '0;
        next_y = '0;
        repeat (3) @(negedge clk);
        chk_rst("init");
        release_rst();

        // 1x window at (240,180)
        step(240, 180, 0, 0, 1, 0, 1);
        step(239, 180, 0, 0, 1, 0, 0);
        step(399, 299, 0, 0, 0, 0, 0);
        step(400, 299, 0, 0, 0, 0, 0);
        // mode change ignored without frame_start
        step(240, 180, 0, 1, 0, 0, 0);
        step(240, 180, 0, 1, 0, 0, 0);
        step(0, 0, 1, 1, 0, 0, 0);
        step(161, 121, 0, 1, 1, 0, 1);
        step(162, 122, 0, 1, 1, 161, 1);
        step(480, 120, 0, 1, 1, 0, 0);
        step(160, 119, 0, 7, 0, 0, 0);
        step(160, 120, 1, 7, 0, 0, 0);
        step(479, 359, 0, 7, 0, 0, 0);
        step(0, 0, 1, 2, 0, 0, 0);
        step(639, 479, 0, 2, 1, 19199, 1);
        step(0, 0, 0, 2, 1, 0, 1);
        step(640, 0, 0, 2, 1, 0, 0);
        step(0, 0, 1, 3, 0, 0, 0);
        step(281, 211, 0, 3, 1, 322, 1);
        step(279, 211, 0, 3, 1, 0, 0);
        step(0, 0, 1, 4, 0, 0, 0);
        step(301, 226, 0, 4, 1, 644, 1);
        step(339, 254, 0, 4, 0, 0, 0);

        for (int it = 0; it < 1500; it++) begin
            int x, y, md;
            bit fs;
            fs = ($urandom_range(0, 63) == 0);
            md = $urandom_range(0, 7);
            if ($urandom_range(0, 9) == 0) begin
                x = $urandom_range(0, 1023);
                y = $urandom_range(0, 1023);
            end else begin
                x = $urandom_range(0, 660);
                y = $urandom_range(0, 500);
            end
            step(x, y, fs, md, 0, 0, 0);
            if (it == 700) begin
                @(posedge clk);
                #2 rst_n = 1'b0;
                #1 chk_rst("midrst");
                aq.delete();
                pq.delete();
                model_mode = 0;
                repeat (3) @(negedge clk);
                chk_rst("hold");
                release_rst();
            end
        end

        for (int k = 0; k < 20 && (aq.size() > 0 || pq.size() > 0); k++) @(negedge clk);
        chk("drain", aq.size() + pq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vga_img_scaler.md
VGA_IMG_SCALER -- requirements
Module: vga_img_scaler

Interface
REQ-001 SHALL have parameter IMG_W, default 160, source image width in pixels.
REQ-002 SHALL have parameter IMG_H, default 120, source image height in pixels.
REQ-003 SHALL have parameter H_ACTIVE, default 640; V_ACTIVE, default 480; visible display area.
REQ-004 SHALL have parameter ADDR_W, default 17, memory address width; PIX_W, default 8, pixel width.
REQ-005 SHALL have parameter MEM_LAT, default 2, external memory read latency in clocks (1..4).
REQ-006 SHALL have parameter BORDER, default 0, pixel value driven outside the image window.
REQ-007 SHALL have ports: clock in 1, pixel clock; reset in 1, asynchronous active-low reset.
REQ-008 SHALL have ports: mode in 3, requested scale mode; frame_start in 1, one-cycle pulse at vblank start.
REQ-009 SHALL have ports: next_x in 10, next_y in 10, coordinate of the pixel to be displayed next.
REQ-010 SHALL have ports: mem_addr out ADDR_W, read address; mem_q in PIX_W, read data.
REQ-011 SHALL have ports: pixel_out out PIX_W, aligned pixel; in_window out 1, pixel_out comes from memory; mode_active out 3, mode in effect.

Function
REQ-012 Modes: 000 1x, 001 zoom 2x, 010 zoom 4x, 011 decimate /2, 100 decimate /4; 101-111 reserved.
REQ-013 mode SHALL be sampled into mode_active only in the cycle frame_start=1; a reserved value SHALL leave mode_active unchanged.
REQ-014 Scaled size SW/SH: 1x IMG_W/IMG_H; zoom k: k*IMG_W/k*IMG_H; decimate k: IMG_W/k, IMG_H/k (integer division).
REQ-015 Window SHALL be centred: OX=(H_ACTIVE-SW)/2, OY=(V_ACTIVE-SH)/2, floor.
REQ-016 Inside iff OX<=next_x<OX+SW and OY<=next_y<OY+SH; next_x>=H_ACTIVE or next_y>=V_ACTIVE is outside.
REQ-017 Source coords: dx=next_x-OX, dy=next_y-OY; zoom k: sx=dx>>log2(k); decimate k: sx=dx<<log2(k); same for y.
REQ-018 mem_addr SHALL equal sy*IMG_W+sx truncated to ADDR_W, registered, one clock after next_x/next_y; 0 when outside.
REQ-019 Multiply SHALL use the constant IMG_W; no general multiplier on the critical path.
REQ-020 Inside flag SHALL pass through a MEM_LAT-deep delay line alongside the memory read.
REQ-021 pixel_out/in_window SHALL be registered, valid exactly 2+MEM_LAT clocks after the coordinate is presented (4 at default).
REQ-022 pixel_out SHALL be mem_q when the delayed flag is 1, else BORDER.
REQ-023 A frame_start pulse SHALL not flush the pipeline; coordinates already in flight finish under the previous mode.
REQ-024 Back-to-back coordinates SHALL be accepted every clock, no stalls.

Reset
REQ-025 While reset=0: mode_active=000, mem_addr=0, pixel_out=BORDER, in_window=0, all delay stages cleared.
REQ-026 Reset asserted mid-frame SHALL take effect immediately and asynchronously; first valid output is 2+MEM_LAT clocks after release.

Structure
REQ-027 Package vga_scaler_pkg SHALL hold mode code constants and default H_ACTIVE/V_ACTIVE timing constants.
REQ-028 Sub-module pipe_delay (params WIDTH, DEPTH, async active-low reset) SHALL implement the flag delay line.
REQ-029 Elaboration SHALL reject 4*IMG_W>H_ACTIVE or 4*IMG_H>V_ACTIVE, or IMG_W*IMG_H>2^ADDR_W.

Verification
REQ-030 1x, (240,180) -> mem_addr=0 after 1 clock; pixel_out=mem_q, in_window=1 after 4 clocks; (239,180) -> BORDER, in_window=0.
REQ-031 2x (OX=160,OY=120): (161,121) -> addr 0; (162,122) -> addr 161; (480,120) -> outside, BORDER.
REQ-032 4x: (639,479) -> addr 19199; (0,0) -> addr 0, in_window=1.
REQ-033 Decimate /2 (OX=280,OY=210): (281,211) -> addr 322; /4 (OX=300,OY=225): (301,226) -> addr 644.
REQ-034 mode=001 mid-frame, no frame_start -> mode_active stays 000; pulse frame_start -> 001 next clock; mode=111 plus pulse -> stays 001.
REQ-035 Reset pulsed during continuous scan -> outputs go to reset values at once; valid pixels resume exactly 4 clocks after release.
